// File: rtl/mp_pkg.sv
// rtl/mp_pkg.sv - shared types and sizing helpers for the result write-back stage
package mp_pkg;

    // Write-back controller states.
    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_ACTIVE = 2'd1,
        WB_FLUSH  = 2'd2
    } wb_state_t;

    localparam int WB_DEPTH_DEFAULT = 8;

    // A count that can hold 0..depth inclusive needs one more bit than the pointers.
    function automatic int wb_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int WB_CNT_W = wb_cnt_w(WB_DEPTH_DEFAULT);

endpackage

// File: rtl/mp_result_writeback_if.sv
// rtl/mp_result_writeback_if.sv - memory write port (req/ack) bundle
//
// mem_req   : write request (master -> slave)
// mem_addr  : word address   (master -> slave)
// mem_wdata : write data     (master -> slave)
// mem_ack   : transfer accepted this cycle (slave -> master)
interface mp_result_writeback_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;

    modport master (output mem_req, output mem_addr, output mem_wdata, input mem_ack);
    modport slave  (input mem_req, input mem_addr, input mem_wdata, output mem_ack);
endinterface

// File: rtl/mp_sync_fifo.sv
// rtl/mp_sync_fifo.sv - first-word-fall-through synchronous FIFO
//
// clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
// push       : write wdata; accepted when not full, or when full with a pop
// pop        : remove head; ignored when empty
// wdata      : data to write
// head       : current oldest entry (valid when !empty)
// count      : number of stored entries
// full       : count == DEPTH, registered from the next count
// empty      : count == 0
module mp_sync_fifo
    import mp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int CNT_W = wb_cnt_w(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              full_q;
    logic              push_ok;
    logic              pop_ok;

    assign pop_ok  = pop && (count_q != '0);
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push_ok = push && (!full_q || pop_ok);
    assign count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/mp_result_writeback.sv
// rtl/mp_result_writeback.sv - buffers controller result words and writes them to memory
//
// clk, rst_n    : clock, synchronous active-low reset
// start         : job start pulse (IDLE only); samples base_addr
// base_addr     : first write address of the job
// res_valid     : result strobe, res_data valid with it
// res_data      : result word
// job_end       : controller issued its last result
// full          : FIFO holds DEPTH words
// almost_full   : FIFO holds at least DEPTH-1 words
// mem           : memory write port (req/addr/wdata out, ack in)
// busy          : state != IDLE
// done          : one-cycle pulse once the job is fully written
// err           : sticky error (overflow drop or result strobe in IDLE)
// words_written : words acknowledged in the current job
module mp_result_writeback
    import mp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    localparam int CNT_W = wb_cnt_w(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic                         res_valid,
    input  logic [DATA_W-1:0]            res_data,
    input  logic                         job_end,
    output logic                         full,
    output logic                         almost_full,
    mp_result_writeback_if.master        mem,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [ADDR_W-1:0]            words_written
);

    wb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ww_q, ww_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              almost_full_q;

    logic              push_req;
    logic              push_acc;
    logic              pop;
    logic              drop;
    logic              mem_req;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_next;
    logic              fifo_full;
    logic              fifo_empty;

    assign push_req = res_valid && (state_q == WB_ACTIVE);
    assign mem_req  = !fifo_empty && (state_q != WB_IDLE);
    assign pop      = mem_req && mem.mem_ack;
    assign push_acc = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    // Mirrors the FIFO's own next count so almost_full lines up with full.
    assign count_next = fifo_count + CNT_W'(push_acc) - CNT_W'(pop);

    mp_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop),
        .wdata (res_data),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= WB_IDLE;
            addr_q        <= '0;
            ww_q          <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            ww_q          <= ww_d;
            err_q         <= err_d;
            done_q        <= done_d;
            almost_full_q <= (count_next >= CNT_W'(DEPTH - 1));
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ww_d    = ww_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            WB_IDLE: begin
                if (start) begin
                    state_d = WB_ACTIVE;
                    addr_d  = base_addr;
                    ww_d    = '0;
                    err_d   = 1'b0;
                end
                // A stray result with nothing to attach it to is always flagged.
                if (res_valid) begin
                    err_d = 1'b1;
                end
            end
            WB_ACTIVE: begin
                if (job_end) begin
                    state_d = WB_FLUSH;
                end
            end
            WB_FLUSH: begin
                // Empty FIFO implies no request outstanding, so the job is complete.
                if (fifo_empty) begin
                    state_d = WB_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase

        // Pops never happen in IDLE, so this cannot collide with the base capture.
        if (pop) begin
            addr_d = addr_q + ADDR_W'(1);
            ww_d   = ww_q + ADDR_W'(1);
        end
        if (drop) begin
            err_d = 1'b1;
        end
    end

    assign mem.mem_req   = mem_req;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = fifo_head;

    assign full          = fifo_full;
    assign almost_full   = almost_full_q;
    assign busy          = (state_q != WB_IDLE);
    assign done          = done_q;
    assign err           = err_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_mp_result_writeback.sv
// tb/tb_mp_result_writeback.sv - self-checking bench with queue-based reference model
module tb_mp_result_writeback;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 8;

    localparam int S_IDLE   = 0;
    localparam int S_ACTIVE = 1;
    localparam int S_FLUSH  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          job_end;
    logic          full;
    logic          almost_full;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] words_written;

    mp_result_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

    mp_result_writeback #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .job_end       (job_end),
        .full          (full),
        .almost_full   (almost_full),
        .mem           (mem_if),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: job state, a plain queue for buffered words, counters.
    int            m_state;
    logic [DW-1:0] m_q[$];
    logic [AW-1:0] m_addr;
    logic [AW-1:0] m_ww;
    logic          m_err;
    logic          m_done;

    int            done_seen;
    logic          last_done;
    logic [AW-1:0] obs_addr[$];
    logic [DW-1:0] obs_data[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_q.delete();
        m_addr  = '0;
        m_ww    = '0;
        m_err   = 1'b0;
        m_done  = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
    task automatic step(input logic st, input logic [AW-1:0] ba, input logic rv,
                        input logic [DW-1:0] rd, input logic je, input logic ack,
                        input logic rn);
        logic m_req;
        logic pop;
        logic was_empty;
        int   old_state;
        start          = st;
        base_addr      = ba;
        res_valid      = rv;
        res_data       = rd;
        job_end        = je;
        mem_if.mem_ack = ack;
        rst_n          = rn;
        @(negedge clk);
        m_req = (m_q.size() > 0) && (m_state != S_IDLE);
        check_eq("mem_req", mem_if.mem_req, m_req);
        check_eq("mem_addr", mem_if.mem_addr, m_addr);
        if (m_req) begin
            check_eq("mem_wdata", mem_if.mem_wdata, m_q[0]);
        end
        check_eq("full", full, m_q.size() == DEPTH);
        check_eq("almost_full", almost_full, m_q.size() >= DEPTH - 1);
        check_eq("busy", busy, m_state != S_IDLE);
        check_eq("done", done, m_done);
        check_eq("err", err, m_err);
        check_eq("words_written", words_written, m_ww);
        last_done = done;
        if (done) done_seen++;
        if (mem_if.mem_req && ack) begin
            obs_addr.push_back(mem_if.mem_addr);
            obs_data.push_back(mem_if.mem_wdata);
        end

        if (!rn) begin
            model_reset();
        end else begin
            pop       = m_req && ack;
            was_empty = (m_q.size() == 0);
            old_state = m_state;
            m_done    = 1'b0;
            case (m_state)
                S_IDLE: begin
                    if (st) begin
                        m_state = S_ACTIVE;
                        m_addr  = ba;
                        m_ww    = '0;
                        m_err   = 1'b0;
                    end
                    if (rv) m_err = 1'b1;
                end
                S_ACTIVE: if (je) m_state = S_FLUSH;
                default: begin
                    if (was_empty) begin
                        m_state = S_IDLE;
                        m_done  = 1'b1;
                    end
                end
            endcase
            if (pop) begin
                void'(m_q.pop_front());
                m_addr = m_addr + 16'd1;
                m_ww   = m_ww + 16'd1;
            end
            if (rv && old_state == S_ACTIVE) begin
                if (m_q.size() >= DEPTH) m_err = 1'b1;
                else m_q.push_back(rd);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, ack, 1'b1);
    endtask

    initial begin
        int ds;
        logic [DW-1:0] words[4];
        words[0] = 32'hAAAA_0001;
        words[1] = 32'hBBBB_0002;
        words[2] = 32'hCCCC_0003;
        words[3] = 32'hDDDD_0004;
        model_reset();
        done_seen = 0;
        last_done = 1'b0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; res_valid = 1'b0;
        res_data = '0; job_end = 1'b0; mem_if.mem_ack = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Basic job at 0x0100 with ack held high.
        ds = done_seen;
        obs_addr.delete(); obs_data.delete();
        step(1'b1, 16'h0100, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, words[i], 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        idle(6, 1'b1);
        check_eq("basic_done_count", done_seen - ds, 1);
        check_eq("basic_words_written", words_written, 4);
        check_eq("basic_xfers", obs_addr.size(), 4);
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            check_eq("basic_addr", obs_addr[i], 16'h0100 + i);
            check_eq("basic_data", obs_data[i], words[i]);
        end

        // Backpressure: 8 words with ack low, then a dropped 9th.
        step(1'b1, 16'h0200, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, $urandom, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        check_eq("bp_full", full, 1);
        check_eq("bp_no_err", err, 0);
        step(1'b0, '0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        check_eq("ovf_err", err, 1);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        idle(12, 1'b1);
        check_eq("ovf_err_sticky", err, 1);
        check_eq("bp_words_written", words_written, 8);
        step(1'b1, 16'h0300, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("start_clears_err", err, 0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Address wrap.
        obs_addr.delete(); obs_data.delete();
        step(1'b1, 16'hFFFE, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, $urandom, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        idle(6, 1'b1);
        check_eq("wrap_xfers", obs_addr.size(), 3);
        if (obs_addr.size() == 3) begin
            check_eq("wrap_a0", obs_addr[0], 16'hFFFE);
            check_eq("wrap_a1", obs_addr[1], 16'hFFFF);
            check_eq("wrap_a2", obs_addr[2], 16'h0000);
        end
        check_eq("wrap_err", err, 0);

        // Reset mid-job with words buffered.
        step(1'b1, 16'h0400, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, $urandom, 1'b0, 1'b0, 1'b1);
        ds = done_seen;
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_mem_req", mem_if.mem_req, 0);
        check_eq("rst_busy", busy, 0);
        idle(5, 1'b1);
        check_eq("rst_no_done", done_seen - ds, 0);

        // job_end together with the last result, and start while busy.
        obs_addr.delete(); obs_data.delete();
        step(1'b1, 16'h0500, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'h0600, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 32'h8765_4321, 1'b1, 1'b1, 1'b1);
        idle(5, 1'b1);
        check_eq("corner_xfers", obs_addr.size(), 2);
        if (obs_addr.size() == 2) begin
            check_eq("busy_start_ignored", obs_addr[0], 16'h0500);
            check_eq("je_word_written", obs_data[1], 32'h8765_4321);
        end

        // Empty job: done two cycles after job_end.
        step(1'b1, 16'h0700, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        check_eq("empty_done_t1", last_done, 0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        check_eq("empty_done_t2", last_done, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) == 0, 16'($urandom), $urandom_range(0, 1) == 1,
                 $urandom, $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 199) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
